frac_clk_div: RTL and testbench
===============================

FRAC_CLK_DIV -- requirements
Module: frac_clk_div

Interface
REQ-001 Parameter INT_W, default 8: width of the integer divisor field.
REQ-002 Parameter FRAC_W, default 8: width of the numerator and denominator fields.
REQ-003 Parameters DEF_INT / DEF_NUM / DEF_DEN, defaults 8 / 7 / 10: divisor loaded at reset (8.7).
REQ-004 clk_in  input  1  input clock; all state on posedge except the half-cycle duty register (negedge).
REQ-005 rst  input  1  synchronous, active-low reset, sampled on clk_in.
REQ-006 enable  input  1  run request; low stops output at the next period boundary.
REQ-007 cfg_valid  input  1  new divisor offered.
REQ-008 cfg_int  input  INT_W  integer part N.
REQ-009 cfg_num  input  FRAC_W  fraction numerator.
REQ-010 cfg_den  input  FRAC_W  fraction denominator.
REQ-011 cfg_ready  output  1  high when no accepted config is pending.
REQ-012 cfg_err  output  1  one-cycle pulse when an offered config is rejected.
REQ-013 clk_out  output  1  divided clock, average ratio N + num/den.
REQ-014 period_start  output  1  one-cycle pulse on the clk_in cycle in which clk_out rises.

Function
REQ-015 The block SHALL accept a config when cfg_valid && cfg_ready, and reject it if cfg_int<2, cfg_den==0 or cfg_num>=cfg_den: cfg_err pulses the next cycle, active config unchanged, nothing queued.
REQ-016 The block SHALL place an accepted config in a shadow register, drop cfg_ready, and apply it at the next period boundary, then raise cfg_ready the cycle after.
REQ-017 The block SHALL clear the accumulator to 0 whenever a new config is applied.
REQ-018 At each period start, the block SHALL compute acc' = acc + num (width FRAC_W+1); if acc' >= den then acc = acc' - den and L = N+1, else acc = acc' and L = N.
REQ-019 Over den consecutive periods, exactly num periods SHALL be N+1 cycles and den-num periods SHALL be N cycles.
REQ-020 The period counter SHALL count 0..L-1 and wrap to 0; wrap defines the period boundary.
REQ-021 clk_out SHALL be high for counter values 0..floor(L/2)-1; for odd L it SHALL additionally stay high for the following half clk_in cycle via a negedge-registered term, giving an exact 50% duty.
REQ-022 With num==0 the block SHALL act as an integer divide-by-N; the case N=2 SHALL give 1 cycle high and 1 cycle low.
REQ-023 When enable is low at a period boundary, the block SHALL hold clk_out at 0 and the counter at 0, and SHALL not assert period_start; it SHALL retain the accumulator and still apply pending configs.
REQ-024 When enable rises, the block SHALL start a new period on the next clk_in posedge.
REQ-025 If a config is pending while disabled, the block SHALL apply it at that boundary, then start with acc=0.
REQ-026 If cfg_valid arrives in the same cycle as a boundary while cfg_ready is high, the block SHALL accept it and apply it at the following boundary, not the current one.
REQ-027 No glitch: clk_out SHALL change only on scheduled edges, including at config switches and enable transitions.

Reset
REQ-028 While rst=0 at a posedge, the block SHALL set clk_out=0 (posedge and negedge terms), period_start=0, cfg_err=0, cfg_ready=1, counter=0, acc=0, active config = DEF_INT/DEF_NUM/DEF_DEN, and clear the shadow register.
REQ-029 The negedge duty register SHALL clear on the first negedge at which rst is low.
REQ-030 Reset applied mid-period SHALL abort the period immediately.
REQ-031 After rst returns high with enable=1, the first period SHALL begin on the first posedge: clk_out=1 and period_start=1.

Verification
REQ-032 Defaults 8.7, enable=1, 870 clk_in cycles -> 100 periods; the first ten lengths are 8,9,9,8,9,9,8,9,9,9 and the sequence repeats every 87 cycles; odd periods are high 4.5 cycles, even periods high 4.
REQ-033 Config 3/0/1 -> period 3, clk_out high 1.5 cycles; config 2/0/1 -> period 2, high 1 cycle.
REQ-034 Config 5/1/4 written mid-period -> cfg_ready low until boundary; the old period completes, then lengths are 5,5,5,6 repeating.
REQ-035 Configs 1/0/1, 4/3/3 and 4/1/0 -> each gives a cfg_err pulse, cfg_ready stays high, output cadence unchanged.
REQ-036 enable dropped mid-period -> the current period completes, then clk_out stays low; on re-enable, accumulator continuity holds (the 8.7 length sequence resumes where it stopped).
REQ-037 rst pulled low at counter=3 of a 9-cycle period -> clk_out=0 the next cycle; after release, the first period is 8 cycles (acc=7).

Source files
------------

// File: rtl/frac_clk_div.sv
// frac_clk_div: fractional clock divider, average ratio N + num/den, 50% duty via a negedge term.
//   clk_in       input clock (posedge state, negedge half-cycle duty register)
//   rst          synchronous active-low reset
//   enable       run request, stops output at the next period boundary when low
//   cfg_valid    new divisor offered on cfg_int / cfg_num / cfg_den
//   cfg_ready    high when no accepted config is waiting for a boundary
//   cfg_err      one-cycle pulse when an offered config is rejected
//   clk_out      divided clock
//   period_start one-cycle pulse in the clk_in cycle where clk_out rises
module frac_clk_div #(
   parameter int INT_W   = 8,
   parameter int FRAC_W  = 8,
   parameter int DEF_INT = 8,
   parameter int DEF_NUM = 7,
   parameter int DEF_DEN = 10
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              enable,
   input  logic              cfg_valid,
   input  logic [INT_W-1:0]  cfg_int,
   input  logic [FRAC_W-1:0] cfg_num,
   input  logic [FRAC_W-1:0] cfg_den,
   output logic              cfg_ready,
   output logic              cfg_err,
   output logic              clk_out,
   output logic              period_start
);
   typedef enum logic {S_IDLE, S_RUN} state_t;
   state_t            state_q, state_d;
   logic [INT_W:0]    cnt_q, cnt_d, len_q, len_d, cnt_inc, half, new_len;
   logic [FRAC_W:0]   acc_q, acc_d, acc_base, sum;
   logic [INT_W-1:0]  int_q, int_d, sh_int_q, sh_int_d;
   logic [FRAC_W-1:0] num_q, num_d, den_q, den_d, sh_num_q, sh_num_d, sh_den_q, sh_den_d;
   logic              pend_q, pend_d, clk_q, clk_d, ext_q, ext_d, ps_q, ps_d, err_q, err_d, neg_q;
   logic              bnd, apply, wrap, start, take, bad;
   always_comb begin
      // idle counts as a permanent boundary so pending configs and enable act at once
      bnd      = (state_q == S_IDLE) | (cnt_q == len_q - 1'b1);
      apply    = bnd & pend_q;
      int_d    = apply ? sh_int_q : int_q;
      num_d    = apply ? sh_num_q : num_q;
      den_d    = apply ? sh_den_q : den_q;
      acc_base = apply ? '0 : acc_q;
      sum      = acc_base + {1'b0, num_d};
      wrap     = sum >= {1'b0, den_d};
      new_len  = {1'b0, int_d} + {{INT_W{1'b0}}, wrap};
      start    = bnd & enable;
      cnt_inc  = cnt_q + 1'b1;
      half     = len_q >> 1;
      state_d  = bnd ? (enable ? S_RUN : S_IDLE) : state_q;
      cnt_d    = bnd ? '0 : cnt_inc;
      len_d    = start ? new_len : len_q;
      acc_d    = start ? (wrap ? sum - {1'b0, den_d} : sum) : acc_base;
      clk_d    = start | (~bnd & (cnt_inc < half));
      // first low cycle of an odd period: the negedge term keeps clk_out high for its first half
      ext_d    = ~bnd & len_q[0] & (cnt_inc == half);
      ps_d     = start;
      take     = cfg_valid & ~pend_q;
      bad      = (cfg_int < INT_W'(2)) | (cfg_den == '0) | (cfg_num >= cfg_den);
      err_d    = take & bad;
      pend_d   = (take & ~bad) | (pend_q & ~bnd);
      sh_int_d = (take & ~bad) ? cfg_int : sh_int_q;
      sh_num_d = (take & ~bad) ? cfg_num : sh_num_q;
      sh_den_d = (take & ~bad) ? cfg_den : sh_den_q;
   end
   always_ff @(posedge clk_in) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         len_q    <= '0;
         acc_q    <= '0;
         int_q    <= INT_W'(DEF_INT);
         num_q    <= FRAC_W'(DEF_NUM);
         den_q    <= FRAC_W'(DEF_DEN);
         sh_int_q <= '0;
         sh_num_q <= '0;
         sh_den_q <= '0;
         pend_q   <= 1'b0;
         clk_q    <= 1'b0;
         ext_q    <= 1'b0;
         ps_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         acc_q    <= acc_d;
         int_q    <= int_d;
         num_q    <= num_d;
         den_q    <= den_d;
         sh_int_q <= sh_int_d;
         sh_num_q <= sh_num_d;
         sh_den_q <= sh_den_d;
         pend_q   <= pend_d;
         clk_q    <= clk_d;
         ext_q    <= ext_d;
         ps_q     <= ps_d;
         err_q    <= err_d;
      end
   end
   always_ff @(negedge clk_in) neg_q <= rst ? clk_q : 1'b0;
   // ext_q gates the negedge term so a posedge reset or period end can never leave a stale half-cycle
   assign clk_out      = clk_q | (ext_q & neg_q);
   assign cfg_ready    = ~pend_q;
   assign cfg_err      = err_q;
   assign period_start = ps_q;
endmodule

// File: tb/tb_frac_clk_div.sv
// tb_frac_clk_div: self-checking bench for frac_clk_div (period-level reference model + vectors).
module tb_frac_clk_div;
   logic       clk_in = 1'b0, rst = 1'b0, enable = 1'b0, cfg_valid = 1'b0;
   logic [7:0] cfg_int = '0, cfg_num = '0, cfg_den = '0;
   logic       cfg_ready, cfg_err, clk_out, period_start;
   int compared = 0, mismatched = 0;

   always #5 clk_in = ~clk_in;

   frac_clk_div dut (
      .clk_in(clk_in), .rst(rst), .enable(enable), .cfg_valid(cfg_valid),
      .cfg_int(cfg_int), .cfg_num(cfg_num), .cfg_den(cfg_den),
      .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_out(clk_out), .period_start(period_start)
   );

   task automatic chk(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: one period at a time, lengths from the accumulator rule
   int m_int = 8, m_num = 7, m_den = 10, m_acc = 0, p_int, p_num, p_den;
   int m_pos = 0, m_len = 0;
   bit m_run = 0, m_pend = 0, m_ps = 0, m_err = 0;

   task automatic model_step();
      bit take, bad, bnd;
      if (!rst) begin
         m_int = 8; m_num = 7; m_den = 10; m_acc = 0;
         m_pend = 0; m_run = 0; m_pos = 0; m_ps = 0; m_err = 0;
      end else begin
         take  = cfg_valid && !m_pend;
         bad   = cfg_int < 2 || cfg_den == 0 || cfg_num >= cfg_den;
         bnd   = !m_run || m_pos == m_len - 1;
         m_err = take && bad;
         m_ps  = 0;
         if (bnd) begin
            if (m_pend) begin
               m_int = p_int; m_num = p_num; m_den = p_den; m_acc = 0; m_pend = 0;
            end
            m_run = enable;
            m_pos = 0;
            if (enable) begin
               m_acc += m_num;
               m_len  = m_int;
               if (m_acc >= m_den) begin
                  m_acc -= m_den;
                  m_len++;
               end
               m_ps = 1;
            end
         end else m_pos++;
         if (take && !bad) begin
            m_pend = 1; p_int = cfg_int; p_num = cfg_num; p_den = cfg_den;
         end
      end
   endtask

   // every cycle: model advances at posedge; outputs compared in both halves of the cycle
   initial forever begin
      @(posedge clk_in);
      model_step();
      #1;
      chk("clk_out_first_half", clk_out, m_run && (m_pos < m_len / 2 || (m_len % 2 == 1 && m_pos == m_len / 2)));
      chk("period_start", period_start, m_ps);
      chk("cfg_err", cfg_err, m_err);
      chk("cfg_ready", cfg_ready, !m_pend);
      @(negedge clk_in);
      #1;
      chk("clk_out_second_half", clk_out, m_run && m_pos < m_len / 2);
   end

   // returns the number of posedges until the next period_start
   task automatic wait_ps(output int n);
      n = 0;
      do begin
         @(posedge clk_in);
         #2;
         n++;
      end while (!period_start && n < 300);
      if (!period_start) begin
         compared++;
         mismatched++;
         $display("FAIL wait_ps: no period_start within %0d cycles", n);
      end
   endtask

   task automatic wait_ready(output int k);
      k = 0;
      while (!cfg_ready && k < 300) begin
         @(posedge clk_in);
         #2;
         k++;
      end
      if (!cfg_ready) begin
         compared++;
         mismatched++;
         $display("FAIL wait_ready: cfg_ready low for %0d cycles", k);
      end
   endtask

   typedef struct {
      int n, num, den;
      bit bad;
      int len[4];
   } vec_t;

   initial begin
      vec_t tbl[9];
      int   seq[10];
      int   n, k;
      seq    = '{8, 9, 9, 8, 9, 9, 8, 9, 9, 9};
      tbl[0] = '{3, 0, 1, 1'b0, '{3, 3, 3, 3}};
      tbl[1] = '{2, 0, 1, 1'b0, '{2, 2, 2, 2}};
      tbl[2] = '{5, 1, 4, 1'b0, '{5, 5, 5, 6}};
      tbl[3] = '{1, 0, 1, 1'b1, '{0, 0, 0, 0}};
      tbl[4] = '{4, 3, 3, 1'b1, '{0, 0, 0, 0}};
      tbl[5] = '{4, 1, 0, 1'b1, '{0, 0, 0, 0}};
      tbl[6] = '{8, 7, 10, 1'b0, '{8, 9, 9, 8}};
      tbl[7] = '{4, 1, 2, 1'b0, '{4, 5, 4, 5}};
      tbl[8] = '{3, 0, 1, 1'b0, '{3, 3, 3, 3}};
      enable = 1'b1;
      repeat (3) @(negedge clk_in);
      chk("reset_cfg_ready", cfg_ready, 1);
      chk("reset_clk_out", clk_out, 0);
      chk("reset_period_start", period_start, 0);
      chk("reset_cfg_err", cfg_err, 0);
      rst = 1'b1;
      wait_ps(n);
      chk("first_period_latency", n, 1);
      for (int i = 0; i < 10; i++) begin
         wait_ps(n);
         chk("len_default_8_7", n, seq[i]);
      end
      // the 11th period starts a new 87-cycle cycle: 8 then 9; reset at counter 3 of the 9
      wait_ps(n);
      chk("len_repeat_first", n, 8);
      repeat (4) @(negedge clk_in);
      rst = 1'b0;
      @(posedge clk_in);
      #1;
      chk("reset_mid_period_clk_out", clk_out, 0);
      @(negedge clk_in);
      rst = 1'b1;
      wait_ps(n);
      chk("restart_latency", n, 1);
      wait_ps(n);
      chk("len_after_reset", n, 8);
      wait_ps(n);
      chk("len_second_after_reset", n, 9);
      // drop enable during the third period; it must complete, then stay idle
      repeat (2) @(negedge clk_in);
      enable = 1'b0;
      repeat (12) @(negedge clk_in);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_in);
         chk("idle_clk_out", clk_out, 0);
         chk("idle_period_start", period_start, 0);
      end
      enable = 1'b1;
      wait_ps(n);
      chk("reenable_latency", n, 1);
      wait_ps(n);
      chk("len_resume_4th", n, 8);
      wait_ps(n);
      chk("len_resume_5th", n, 9);
      // configuration vectors
      for (int i = 0; i < 9; i++) begin
         wait_ready(k);
         @(negedge clk_in);
         cfg_int   = 8'(tbl[i].n);
         cfg_num   = 8'(tbl[i].num);
         cfg_den   = 8'(tbl[i].den);
         cfg_valid = 1'b1;
         @(negedge clk_in);
         cfg_valid = 1'b0;
         chk("vec_cfg_err", cfg_err, tbl[i].bad);
         chk("vec_cfg_ready", cfg_ready, tbl[i].bad);
         if (!tbl[i].bad) begin
            wait_ready(k);
            chk("vec_apply_at_boundary", period_start, 1);
            for (int j = 0; j < 4; j++) begin
               wait_ps(n);
               chk("vec_len", n, tbl[i].len[j]);
            end
         end
      end
      // config offered in the boundary cycle applies at the following boundary
      repeat (3) @(negedge clk_in);
      cfg_int   = 8'd5;
      cfg_num   = 8'd0;
      cfg_den   = 8'd1;
      cfg_valid = 1'b1;
      @(posedge clk_in);
      #2;
      cfg_valid = 1'b0;
      chk("boundary_cfg_start", period_start, 1);
      chk("boundary_cfg_pending", cfg_ready, 0);
      wait_ps(n);
      chk("boundary_cfg_old_len", n, 3);
      wait_ps(n);
      chk("boundary_cfg_new_len", n, 5);
      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk_in);
         rst       = $urandom_range(0, 399) != 0;
         if ($urandom_range(0, 39) == 0) enable = ~enable;
         cfg_valid = $urandom_range(0, 15) == 0;
         cfg_int   = 8'($urandom_range(0, 7));
         cfg_num   = 8'($urandom_range(0, 7));
         cfg_den   = 8'($urandom_range(0, 7));
      end
      @(negedge clk_in);
      cfg_valid = 1'b0;
      rst       = 1'b1;
      repeat (20) @(negedge clk_in);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
